// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared constants for the PS/2 scan-code decoder.
// Holds the receive-frame FSM state encoding and the special scan codes.
package ps2_pkg;

   // Frame receive FSM states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // Scan-code set 2 special bytes
   localparam logic [7:0] BREAK  = 8'hF0;
   localparam logic [7:0] EXT    = 8'hE0;
   localparam logic [7:0] LSHIFT = 8'h12;
   localparam logic [7:0] RSHIFT = 8'h59;
   localparam logic [7:0] CAPS   = 8'h58;

   // True for the codes that drive modifier state instead of being emitted
   function automatic logic is_modifier(input logic [7:0] code);
      return (code == LSHIFT) || (code == RSHIFT) || (code == CAPS);
   endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// ps2_scan_decoder_if -- decoded key stream from the PS/2 decoder.
// The decoder drives it through the master modport; consumers use slave.
interface ps2_scan_decoder_if;
   logic [7:0] scancode;
   logic       scan_valid;
   logic       extended;
   logic       shift;
   logic       caps;
   logic       frame_err;

   modport master (output scancode, scan_valid, extended, shift, caps, frame_err);
   modport slave  (input  scancode, scan_valid, extended, shift, caps, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame -- PS/2 byte receiver: input synchronizers, 11-bit frame FSM,
// odd-parity/stop check and optional inactivity timeout (PS2_TIMEOUT_EN).
// byte_valid / frame_err are combinational strobes valid in the cycle the
// stop-bit edge (or timeout) is seen; the decoder registers them.
import ps2_pkg::*;

module ps2_rx_frame #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       frame_timeout
);

   logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
   logic       data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   logic [1:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic       parity_q, parity_d;
   logic       sample_edge;

`ifdef PS2_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

   // Falling edge of the synchronized keyboard clock
   assign sample_edge = clk_prev_q & ~clk_s2_q;

   // Next-state logic: synchronizer chain, frame FSM, parity/stop check, timeout
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      clk_s1_d      = ps2_clk;
      clk_s2_d      = clk_s1_q;
      clk_prev_d    = clk_s2_q;
      data_s1_d     = ps2_data;
      data_s2_d     = data_s1_q;
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shreg_d       = shreg_q;
      parity_d      = parity_q;
      rx_byte       = shreg_q;
      byte_valid    = 1'b0;
      frame_err     = 1'b0;
      frame_timeout = 1'b0;

      if (sample_edge) begin
         case (state_q)
            ST_IDLE: begin
               if (!data_s2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shreg_d   = {data_s2_q, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               parity_d = data_s2_q;
               state_d  = ST_STOP;
            end
            default: begin
               // Data plus parity must hold an odd number of ones
               if (data_s2_q && (^{shreg_q, parity_q})) byte_valid = 1'b1;
               else                                     frame_err  = 1'b1;
               state_d = ST_IDLE;
            end
         endcase
      end

`ifdef PS2_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      if (sample_edge) begin
         tmo_cnt_d = '0;
      end else if (state_q != ST_IDLE) begin
         if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt_d     = '0;
            state_d       = ST_IDLE;
            bit_cnt_d     = 3'd0;
            frame_err     = 1'b1;
            frame_timeout = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
         end
      end
`endif
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         // Synchronizers reset to the idle-high line level so reset never fakes an edge
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shreg_q    <= 8'h00;
         parity_q   <= 1'b0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         clk_prev_q <= clk_prev_d;
         data_s1_q  <= data_s1_d;
         data_s2_q  <= data_s2_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         parity_q   <= parity_d;
      end
   end

`ifdef PS2_TIMEOUT_EN
   // Inactivity counter register
   always_ff @(posedge clk) begin
      if (rst) tmo_cnt_q <= '0;
      else     tmo_cnt_q <= tmo_cnt_d;
   end
`endif

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder -- PS/2 keyboard scan-code set 2 decoder.
// Receives bytes via ps2_rx_frame, tracks break/extended prefixes and the
// shift/caps modifiers, and emits make codes as one-cycle strobes.
// Optional feature: define PS2_TIMEOUT_EN to abandon stalled frames after
// TIMEOUT_CYCLES clk cycles.
import ps2_pkg::*;

module ps2_scan_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ps2_clk,
   input  logic                  ps2_data,
   ps2_scan_decoder_if.master    out_if
);

   logic [7:0] rx_byte;
   logic       rx_byte_valid, rx_frame_err, rx_timeout;

   logic [7:0] scancode_q, scancode_d;
   logic       extended_q, extended_d;
   logic       scan_valid_q, scan_valid_d;
   logic       frame_err_q, frame_err_d;
   logic       lshift_q, lshift_d, rshift_q, rshift_d;
   logic       caps_q, caps_d, caps_held_q, caps_held_d;
   logic       break_pending_q, break_pending_d, ext_pending_q, ext_pending_d;

   ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk           (clk),
      .rst           (rst),
      .ps2_clk       (ps2_clk),
      .ps2_data      (ps2_data),
      .rx_byte       (rx_byte),
      .byte_valid    (rx_byte_valid),
      .frame_err     (rx_frame_err),
      .frame_timeout (rx_timeout)
   );

   // Byte interpretation: prefixes, modifier tracking and make-code emission
   always_comb begin
      scancode_d      = scancode_q;
      extended_d      = extended_q;
      scan_valid_d    = 1'b0;
      frame_err_d     = rx_frame_err;
      lshift_d        = lshift_q;
      rshift_d        = rshift_q;
      caps_d          = caps_q;
      caps_held_d     = caps_held_q;
      break_pending_d = break_pending_q;
      ext_pending_d   = ext_pending_q;

      if (rx_byte_valid) begin
         if (rx_byte == BREAK) begin
            break_pending_d = 1'b1;
         end else if (rx_byte == EXT) begin
            ext_pending_d = 1'b1;
         end else begin
            if (!ext_pending_q && is_modifier(rx_byte)) begin
               if (break_pending_q) begin
                  if (rx_byte == LSHIFT) lshift_d    = 1'b0;
                  if (rx_byte == RSHIFT) rshift_d    = 1'b0;
                  if (rx_byte == CAPS)   caps_held_d = 1'b0;
               end else begin
                  if (rx_byte == LSHIFT) lshift_d = 1'b1;
                  if (rx_byte == RSHIFT) rshift_d = 1'b1;
                  if (rx_byte == CAPS) begin
                     // Typematic repeats arrive while held and must not toggle
                     if (!caps_held_q) caps_d = ~caps_q;
                     caps_held_d = 1'b1;
                  end
               end
            end else if (!break_pending_q) begin
               scancode_d   = rx_byte;
               extended_d   = ext_pending_q;
               scan_valid_d = 1'b1;
            end
            break_pending_d = 1'b0;
            ext_pending_d   = 1'b0;
         end
      end

      // An abandoned frame may have followed a prefix; drop the prefix too
      if (rx_timeout) begin
         break_pending_d = 1'b0;
         ext_pending_d   = 1'b0;
      end
   end

   // Decoder registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         scancode_q      <= 8'h00;
         extended_q      <= 1'b0;
         scan_valid_q    <= 1'b0;
         frame_err_q     <= 1'b0;
         lshift_q        <= 1'b0;
         rshift_q        <= 1'b0;
         caps_q          <= 1'b0;
         caps_held_q     <= 1'b0;
         break_pending_q <= 1'b0;
         ext_pending_q   <= 1'b0;
      end else begin
         scancode_q      <= scancode_d;
         extended_q      <= extended_d;
         scan_valid_q    <= scan_valid_d;
         frame_err_q     <= frame_err_d;
         lshift_q        <= lshift_d;
         rshift_q        <= rshift_d;
         caps_q          <= caps_d;
         caps_held_q     <= caps_held_d;
         break_pending_q <= break_pending_d;
         ext_pending_q   <= ext_pending_d;
      end
   end

   assign out_if.scancode   = scancode_q;
   assign out_if.extended   = extended_q;
   assign out_if.scan_valid = scan_valid_q;
   assign out_if.frame_err  = frame_err_q;
   assign out_if.shift      = lshift_q | rshift_q;
   assign out_if.caps       = caps_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder -- self-checking bench for ps2_scan_decoder.
// A key-level model (set of held keys, prefix flags, expected strobe counts)
// predicts the outputs for directed sequences and a random byte stream.
module tb_ps2_scan_decoder;

   localparam int unsigned TMO = 300;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   always #5 clk = ~clk;

   ps2_scan_decoder_if u_if ();

   ps2_scan_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .out_if   (u_if)
   );

   int checks = 0;
   int errors = 0;

   // Strobe monitor: counts pulses and flags overlap or multi-cycle pulses
   int   sv_cnt = 0, fe_cnt = 0;
   bit   overlap_seen = 0, long_sv = 0, long_fe = 0;
   logic prev_sv = 1'b0, prev_fe = 1'b0;

   always @(negedge clk) begin
      if (u_if.scan_valid === 1'b1) sv_cnt <= sv_cnt + 1;
      if (u_if.frame_err === 1'b1)  fe_cnt <= fe_cnt + 1;
      if (u_if.scan_valid === 1'b1 && u_if.frame_err === 1'b1) overlap_seen <= 1'b1;
      if (u_if.scan_valid === 1'b1 && prev_sv === 1'b1) long_sv <= 1'b1;
      if (u_if.frame_err === 1'b1 && prev_fe === 1'b1)  long_fe <= 1'b1;
      prev_sv <= u_if.scan_valid;
      prev_fe <= u_if.frame_err;
   end

   // Reference model state
   bit         held [256];
   bit         m_break, m_ext, m_caps, m_extd;
   logic [7:0] m_code;
   int         exp_sv = 0, exp_fe = 0;

   function void model_reset();
      for (int i = 0; i < 256; i++) held[i] = 1'b0;
      m_break = 0; m_ext = 0; m_caps = 0; m_extd = 0; m_code = 8'h00;
   endfunction

   function void model_byte(input logic [7:0] b);
      if (b == 8'hF0) m_break = 1;
      else if (b == 8'hE0) m_ext = 1;
      else begin
         if (!m_ext && (b == 8'h12 || b == 8'h59 || b == 8'h58)) begin
            if (m_break) held[b] = 1'b0;
            else begin
               if (b == 8'h58 && !held[8'h58]) m_caps = !m_caps;
               held[b] = 1'b1;
            end
         end else if (!m_break) begin
            m_code = b; m_extd = m_ext; exp_sv++;
         end
         m_break = 0; m_ext = 0;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame bits, index 0 first on the wire: start, data LSB first, parity, stop
   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^b) ^ bad_par;
      return {~bad_stop, par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (3) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (5) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (3) @(negedge clk);
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(mk_frame(b, 0, 0), 11);
      model_byte(b);
   endtask

   task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      send_bits(mk_frame(b, bad_par, bad_stop), 11);
      exp_fe++;
   endtask

   task automatic check_state(input string tag);
      repeat (3) @(negedge clk);
      #1;
      check({tag, ".sv_count"}, sv_cnt, exp_sv);
      check({tag, ".fe_count"}, fe_cnt, exp_fe);
      check({tag, ".shift"}, u_if.shift, held[8'h12] | held[8'h59]);
      check({tag, ".caps"}, u_if.caps, m_caps);
      check({tag, ".scancode"}, u_if.scancode, m_code);
      check({tag, ".extended"}, u_if.extended, m_extd);
   endtask

   // Time limit so a stuck design still ends the run
   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "time limit");
   end

   initial begin
      logic [10:0] f;
      logic [7:0]  rb;
      int          r;

      model_reset();

      // Reset state
      repeat (4) @(negedge clk);
      check("rst.scancode", u_if.scancode, 8'h00);
      check("rst.scan_valid", u_if.scan_valid, 1'b0);
      check("rst.extended", u_if.extended, 1'b0);
      check("rst.shift", u_if.shift, 1'b0);
      check("rst.caps", u_if.caps, 1'b0);
      check("rst.frame_err", u_if.frame_err, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Frame 1C with exact strobe latency and width
      f = mk_frame(8'h1C, 0, 0);
      send_bits(f, 10);
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("lat.early", u_if.scan_valid, 1'b0);
      @(negedge clk);
      check("lat.strobe", u_if.scan_valid, 1'b1);
      check("lat.scancode", u_if.scancode, 8'h1C);
      @(negedge clk);
      check("lat.width", u_if.scan_valid, 1'b0);
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
      model_byte(8'h1C);
      check_state("f1c");

      // Shift make, key, key break, shift break
      send_byte(8'h12); check_state("sh.make");
      send_byte(8'h1C); check_state("sh.key");
      send_byte(8'hF0); send_byte(8'h1C); check_state("sh.keybrk");
      send_byte(8'hF0); send_byte(8'h12); check_state("sh.brk");

      // Both shifts overlapping
      send_byte(8'h12); send_byte(8'h59);
      send_byte(8'hF0); send_byte(8'h12); check_state("dual.l_up");
      send_byte(8'hF0); send_byte(8'h59); check_state("dual.r_up");

      // Caps lock with typematic repeats
      send_byte(8'h58); check_state("caps.1");
      send_byte(8'h58); check_state("caps.rep1");
      send_byte(8'h58); check_state("caps.rep2");
      send_byte(8'hF0); send_byte(8'h58); check_state("caps.brk");
      send_byte(8'h58); check_state("caps.2");

      // Extended make, extended break, bad parity, bad stop
      send_byte(8'hE0); send_byte(8'h75); check_state("ext.make");
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); check_state("ext.brk");
      send_bad(8'h2A, 1, 0); check_state("err.parity");
      send_bad(8'h2A, 0, 1); check_state("err.stop");

`ifdef PS2_TIMEOUT_EN
      // Stalled frame after 4 data bits is abandoned; the E0 prefix is dropped
      send_byte(8'hE0);
      send_bits(mk_frame(8'h33, 0, 0), 5);
      repeat (TMO + 20) @(negedge clk);
      exp_fe++; m_ext = 0; m_break = 0;
      check_state("tmo.err");
      send_byte(8'h1C); check_state("tmo.next");
`else
      // Without the timeout a stalled frame simply resumes
      send_byte(8'hE0);
      f = mk_frame(8'h75, 0, 0);
      send_bits(f, 5);
      repeat (TMO + 20) @(negedge clk);
      check("stall.no_err", fe_cnt, exp_fe);
      send_bits(f >> 5, 6);
      model_byte(8'h75);
      check_state("stall.resume");
`endif

      // Reset in the middle of a frame
      send_byte(8'h12); send_byte(8'h58); send_byte(8'hE0);
      send_bits(mk_frame(8'h4D, 0, 0), 5);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      m_code = 8'h00;
      check_state("midrst");
      send_byte(8'h1C); check_state("midrst.next");

      // Random byte stream
      for (int n = 0; n < 150; n++) begin
         r  = $urandom_range(0, 9);
         rb = 8'($urandom);
         case (r)
            0: send_byte(8'h12);
            1: send_byte(8'h59);
            2: send_byte(8'h58);
            3: send_byte(8'hF0);
            4: send_byte(8'hE0);
            9: send_bad(rb, 1, 0);
            default: send_byte(rb);
         endcase
         if (n % 5 == 4) check_state("rand");
      end
      check_state("rand.end");

      check("strobe.overlap", overlap_seen, 1'b0);
      check("strobe.sv_width", long_sv, 1'b0);
      check("strobe.fe_width", long_fe, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
